// File: rtl/tlv5618_pkg.sv
// Shared definitions for the TLV5618 update scheduler: R-code constants,
// FSM state and channel-select enums, and the control-word packer.
package tlv5618_pkg;

   localparam logic [1:0] RC_B_BUF = 2'b00;  // write B and buffer
   localparam logic [1:0] RC_BUF   = 2'b01;  // write buffer only
   localparam logic [1:0] RC_A_UPD = 2'b10;  // write A, load B from buffer

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_GAP
   } sched_state_t;

   typedef enum logic {
      CH_A,
      CH_B
   } ch_sel_t;

   // Control word layout: {R1, SPD, PWR, R0, code[11:0]}
   function automatic logic [15:0] pack_word(input logic [1:0]  rc,
                                             input logic        spd,
                                             input logic        pwr,
                                             input logic [11:0] code);
      return {rc[1], spd, pwr, rc[0], code};
   endfunction

endpackage

// File: rtl/tlv5618_ch_slot.sv
// One channel holding slot: pending flag, newest-wins value register and a
// one-cycle acknowledge. A request in the same cycle as the issue-clear keeps
// the slot pending with the new value.
module tlv5618_ch_slot (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic [11:0] data_i,
   input  logic        clr_i,
   output logic        pend_o,
   output logic [11:0] val_o,
   output logic        ack_o
);

   logic        pend_q;
   logic [11:0] val_q;
   logic        ack_q;

   // Slot state: set has priority over clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= 1'b0;
         val_q  <= 12'h000;
         ack_q  <= 1'b0;
      end else begin
         ack_q <= req_i;
         if (req_i) begin
            pend_q <= 1'b1;
            val_q  <= data_i;
         end else if (clr_i) begin
            pend_q <= 1'b0;
         end
      end
   end

   assign pend_o = pend_q;
   assign val_o  = val_q;
   assign ack_o  = ack_q;

endmodule

// File: rtl/tlv5618_update_sched.sv
// TLV5618 channel scheduler: holds A/B codes and issues control words to the
// serial frame driver one at a time, spacing frames by GAP_CYCLES.
// Optional feature macro: TLV5618_SYNC_UPDATE_EN (both pending -> B goes to
// the buffer only, so A and B outputs change together on the A frame).
//
// state      | meaning
// IDLE       | nothing in flight, waiting for a pending slot
// ISSUE      | drv_go pulse, word presented, chosen slot cleared
// WAIT_DONE  | frame shifting out, waiting for drv_done
// GAP        | inter-frame idle countdown, then next frame or IDLE
module tlv5618_update_sched
   import tlv5618_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic [11:0] a_data,
   output logic        a_ack,
   input  logic        b_req,
   input  logic [11:0] b_data,
   output logic        b_ack,
   input  logic        spd_fast,
   input  logic        pwr_dn,
   output logic [15:0] drv_data,
   output logic        drv_go,
   input  logic        drv_done,
   output logic        busy
);

   localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

`ifdef TLV5618_SYNC_UPDATE_EN
   localparam logic [1:0] RC_PAIR_B = RC_BUF;
`else
   localparam logic [1:0] RC_PAIR_B = RC_B_BUF;
`endif

   sched_state_t   state_q, state_d;
   ch_sel_t        sel_q, sel_d;
   logic [1:0]     rc_q, rc_d;
   logic           pair_q, pair_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [15:0]    drv_data_q;

   logic           a_pend, b_pend;
   logic [11:0]    a_val, b_val;
   logic           dec_go, dec_pair;
   ch_sel_t        dec_sel;
   logic [1:0]     dec_rc;
   logic           frame_end;
   logic [15:0]    word;

   tlv5618_ch_slot u_slot_a (
      .clk    (clk),
      .rst    (rst),
      .req_i  (a_req),
      .data_i (a_data),
      .clr_i  ((state_q == ST_ISSUE) && (sel_q == CH_A)),
      .pend_o (a_pend),
      .val_o  (a_val),
      .ack_o  (a_ack)
   );

   tlv5618_ch_slot u_slot_b (
      .clk    (clk),
      .rst    (rst),
      .req_i  (b_req),
      .data_i (b_data),
      .clr_i  ((state_q == ST_ISSUE) && (sel_q == CH_B)),
      .pend_o (b_pend),
      .val_o  (b_val),
      .ack_o  (b_ack)
   );

   // Choice of next frame from the pending flags (B first when both pending)
   always_comb begin
      dec_go   = a_pend | b_pend;
      dec_sel  = CH_B;
      dec_rc   = RC_B_BUF;
      dec_pair = 1'b0;
      if (a_pend && b_pend) begin
         dec_rc   = RC_PAIR_B;
         dec_pair = 1'b1;
      end else if (a_pend) begin
         dec_sel  = CH_A;
         dec_rc   = RC_A_UPD;
      end
   end

   // Next-state logic; frame end chains straight into the next ISSUE
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      rc_d      = rc_q;
      pair_d    = pair_q;
      cnt_d     = cnt_q;
      frame_end = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dec_go) begin
               state_d = ST_ISSUE;
               sel_d   = dec_sel;
               rc_d    = dec_rc;
               pair_d  = dec_pair;
            end
         end
         ST_ISSUE: state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (drv_done) begin
               if (GAP_CYCLES == 0) begin
                  frame_end = 1'b1;
               end else begin
                  state_d = ST_GAP;
                  cnt_d   = CW'(GAP_CYCLES - 1);
               end
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) frame_end = 1'b1;
            else             cnt_d     = cnt_q - CW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
      if (frame_end) begin
         if (pair_q) begin
            state_d = ST_ISSUE;
            sel_d   = CH_A;
            rc_d    = RC_A_UPD;
            pair_d  = 1'b0;
         end else if (dec_go) begin
            state_d = ST_ISSUE;
            sel_d   = dec_sel;
            rc_d    = dec_rc;
            pair_d  = dec_pair;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // FSM and issue-snapshot registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sel_q      <= CH_A;
         rc_q       <= RC_B_BUF;
         pair_q     <= 1'b0;
         cnt_q      <= '0;
         drv_data_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rc_q    <= rc_d;
         pair_q  <= pair_d;
         cnt_q   <= cnt_d;
         if (state_q == ST_ISSUE) drv_data_q <= word;
      end
   end

   // The word is live during ISSUE and then held in drv_data_q
   assign word     = pack_word(rc_q, spd_fast, pwr_dn, (sel_q == CH_A) ? a_val : b_val);
   assign drv_data = (state_q == ST_ISSUE) ? word : drv_data_q;
   assign drv_go   = (state_q == ST_ISSUE);
   assign busy     = (state_q != ST_IDLE);

endmodule
